// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 byte sequencer: each accepted host command becomes one MSB-first transfer,
// with optional chip-select hold across back-to-back bytes to the same slave.
module spi_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int CS_W   = 2,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CS_W-1:0]   cmd_cs_idx,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_last,
    input  logic [DIV_W-1:0]  cmd_div,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              s_clk,
    output logic [NUM_CS-1:0] m_chip_sel,
    output logic              mosi,
    input  logic              miso
);

    localparam int BC_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]  div_q, half_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [CS_W-1:0]   idx_q, held_idx;
    logic              last_q, held;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [NUM_CS-1:0] cs_q, cs_decode;
    logic              mosi_q, s_clk_q;
    logic              accept, phase_end;
    logic [CS_W-1:0]   setup_idx;
    logic              setup_msb;

    // Command handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; rsp_valid is a one-cycle pulse with no backpressure.
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (half_cnt == div_q);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (held && (held_idx != cmd_cs_idx)) ? S_GAP : S_SETUP;
            S_GAP:   if (phase_end) state_next = S_SETUP;
            S_SETUP: if (phase_end) state_next = S_HIGH;
            S_HIGH:  if (phase_end) state_next = S_LOW;
            S_LOW:   if (phase_end) state_next = (bit_cnt == BC_W'(DATA_W)) ? S_DONE : S_HIGH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // SETUP is entered straight from IDLE (command not yet latched) or from GAP.
    assign setup_idx = (state == S_IDLE) ? cmd_cs_idx : idx_q;
    assign setup_msb = (state == S_IDLE) ? cmd_data[DATA_W-1] : tx_sr[DATA_W-1];

    always_comb begin
        cs_decode = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (setup_idx == CS_W'(i)) cs_decode[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            idx_q    <= '0;
            held_idx <= '0;
            last_q   <= 1'b0;
            held     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cs_q     <= '0;
            mosi_q   <= 1'b0;
            s_clk_q  <= 1'b0;
        end else begin
            half_cnt <= ((state_next != state) || (state == S_IDLE)) ? '0 : half_cnt + 1'b1;
            s_clk_q  <= (state_next == S_HIGH);

            if (accept) begin
                tx_sr   <= cmd_data;
                idx_q   <= cmd_cs_idx;
                last_q  <= cmd_last;
                div_q   <= cmd_div;
                bit_cnt <= '0;
            end

            if (state_next == S_GAP && state != S_GAP) begin
                cs_q <= '0;
                held <= 1'b0;
            end

            if (state_next == S_SETUP && state != S_SETUP) begin
                cs_q   <= cs_decode;
                mosi_q <= setup_msb;
            end

            if (state_next == S_HIGH && state != S_HIGH) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end

            if (state_next == S_LOW && state != S_LOW) begin
                tx_sr   <= tx_sr << 1;
                mosi_q  <= tx_sr[DATA_W-2];
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Leaving DONE: either release the slave or remember it for the next byte.
            if (state == S_DONE) begin
                mosi_q   <= 1'b0;
                held     <= !last_q;
                held_idx <= idx_q;
                if (last_q) cs_q <= '0;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign s_clk      = s_clk_q;
    assign rsp_valid  = (state == S_DONE);
    assign rsp_data   = rx_sr;
    assign m_chip_sel = cs_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a cycle-indexed transfer model (phase arithmetic on H) checked
// every cycle against a 4-slave instance and a 3-slave instance sharing the same inputs.
module tb_spi_xfer_ctrl;

    localparam int DATA_W = 8;
    localparam int CS_W   = 2;
    localparam int DIV_W  = 8;
    localparam int NCS_A  = 4;
    localparam int NCS_B  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [CS_W-1:0]   cmd_cs_idx = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cmd_last = 1'b0;
    logic [DIV_W-1:0]  cmd_div = '0;
    logic              miso;
    logic              miso_drv = 1'b0;
    logic              loopback = 1'b0;

    logic              cmd_ready_a, rsp_valid_a, busy_a, s_clk_a, mosi_a;
    logic              cmd_ready_b, rsp_valid_b, busy_b, s_clk_b, mosi_b;
    logic [DATA_W-1:0] rsp_data_a, rsp_data_b;
    logic [NCS_A-1:0]  cs_a;
    logic [NCS_B-1:0]  cs_b;

    assign miso = loopback ? mosi_a : miso_drv;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DATA_W(DATA_W), .NUM_CS(NCS_A), .CS_W(CS_W), .DIV_W(DIV_W)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
        .cmd_cs_idx(cmd_cs_idx), .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_div(cmd_div),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a), .s_clk(s_clk_a),
        .m_chip_sel(cs_a), .mosi(mosi_a), .miso(miso)
    );

    spi_xfer_ctrl #(.DATA_W(DATA_W), .NUM_CS(NCS_B), .CS_W(CS_W), .DIV_W(DIV_W)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_cs_idx(cmd_cs_idx), .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_div(cmd_div),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b), .s_clk(s_clk_b),
        .m_chip_sel(cs_b), .mosi(mosi_b), .miso(miso)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_fail_print = 0;

    bit              m_held = 1'b0;
    logic [CS_W-1:0] m_held_idx = '0;

    int                obs_rsp_k;
    int                obs_rises;
    logic [DATA_W-1:0] obs_mosi;
    logic [DATA_W-1:0] obs_rsp;
    logic [NCS_A-1:0]  obs_cs_a;
    logic [NCS_B-1:0]  obs_cs_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            if (n_fail_print < 50) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
            n_fail_print++;
        end
    endtask

    function automatic logic [NCS_A-1:0] cs_vec(input logic [CS_W-1:0] idx, input int ncs);
        cs_vec = '0;
        if (int'(idx) < ncs) cs_vec[idx] = 1'b1;
    endfunction

    task automatic check_cycle(input string tag, input int k, input logic e_busy, input logic e_ready,
                               input logic e_sclk, input logic e_rsp,
                               input logic [NCS_A-1:0] e_cs_a, input logic [NCS_A-1:0] e_cs_b,
                               input logic e_mchk, input logic e_mosi,
                               input logic e_dchk, input logic [DATA_W-1:0] e_data);
        string s;
        s = $sformatf("%s k=%0d", tag, k);
        check({s, " busy_a"}, busy_a, e_busy);
        check({s, " busy_b"}, busy_b, e_busy);
        check({s, " ready_a"}, cmd_ready_a, e_ready);
        check({s, " ready_b"}, cmd_ready_b, e_ready);
        check({s, " s_clk_a"}, s_clk_a, e_sclk);
        check({s, " s_clk_b"}, s_clk_b, e_sclk);
        check({s, " rsp_valid_a"}, rsp_valid_a, e_rsp);
        check({s, " rsp_valid_b"}, rsp_valid_b, e_rsp);
        check({s, " cs_a"}, cs_a, e_cs_a);
        check({s, " cs_b"}, cs_b, e_cs_b);
        if (e_mchk) begin
            check({s, " mosi_a"}, mosi_a, e_mosi);
            check({s, " mosi_b"}, mosi_b, e_mosi);
        end
        if (e_dchk) begin
            check({s, " rsp_data_a"}, rsp_data_a, e_data);
            check({s, " rsp_data_b"}, rsp_data_b, e_data);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy_a"}, busy_a, 0);
        check({tag, " busy_b"}, busy_b, 0);
        check({tag, " ready_a"}, cmd_ready_a, 0);
        check({tag, " ready_b"}, cmd_ready_b, 0);
        check({tag, " s_clk_a"}, s_clk_a, 0);
        check({tag, " s_clk_b"}, s_clk_b, 0);
        check({tag, " rsp_valid_a"}, rsp_valid_a, 0);
        check({tag, " rsp_valid_b"}, rsp_valid_b, 0);
        check({tag, " cs_a"}, cs_a, 0);
        check({tag, " cs_b"}, cs_b, 0);
        check({tag, " mosi_a"}, mosi_a, 0);
        check({tag, " mosi_b"}, mosi_b, 0);
        check({tag, " rsp_data_a"}, rsp_data_a, 0);
        check({tag, " rsp_data_b"}, rsp_data_b, 0);
    endtask

    // mode: 0 = miso looped from mosi, 1 = miso tied high, 2 = random miso per cycle.
    // Called just after a falling edge with the controller idle.
    task automatic do_xfer(input string tag, input logic [CS_W-1:0] idx, input logic [DATA_W-1:0] data,
                           input logic last, input logic [DIV_W-1:0] div, input int mode,
                           input bit hold_valid, input bit abort_mid);
        int h, gap, t, jj, p, bi, abort_k;
        bit aborted;
        logic e_sclk, e_rsp, e_sel, e_mchk, e_mosi, prev_sclk;
        logic [DATA_W-1:0] e_rx;
        logic miso_hist[0:4095];

        h       = int'(div) + 1;
        gap     = (m_held && (m_held_idx != idx)) ? h : 0;
        t       = gap + h + 2 * DATA_W * h + 1;
        abort_k = abort_mid ? (1 + gap + 7 * h) : -1;
        aborted = 1'b0;
        for (int i = 0; i < 4096; i++) miso_hist[i] = 1'b0;

        loopback   = (mode == 0);
        miso_drv   = (mode == 1);
        cmd_cs_idx = idx;
        cmd_data   = data;
        cmd_last   = last;
        cmd_div    = div;
        cmd_valid  = 1'b1;
        #1;
        check({tag, " accept ready_a"}, cmd_ready_a, 1);
        check({tag, " accept ready_b"}, cmd_ready_b, 1);

        obs_rsp_k = -1;
        obs_rises = 0;
        obs_mosi  = '0;
        obs_rsp   = '0;
        obs_cs_a  = '0;
        obs_cs_b  = '0;
        prev_sclk = 1'b0;

        @(posedge clk);
        #1;
        if (hold_valid) begin
            cmd_cs_idx = CS_W'($urandom_range(0, 3));
            cmd_data   = DATA_W'($urandom_range(0, 255));
            cmd_last   = 1'($urandom_range(0, 1));
            cmd_div    = DIV_W'($urandom_range(0, 3));
        end else begin
            cmd_valid = 1'b0;
        end

        for (int k = 1; k <= t; k++) begin
            @(negedge clk);
            jj     = k - 1;
            e_sclk = 1'b0;
            e_rsp  = 1'b0;
            e_sel  = 1'b1;
            e_mchk = 1'b0;
            e_mosi = 1'b0;
            e_rx   = '0;
            if (jj < gap) begin
                e_sel = 1'b0;
            end else begin
                jj = jj - gap;
                if (jj < h) begin
                    e_mchk = 1'b1;
                    e_mosi = data[DATA_W-1];
                end else if (jj < h + 2 * DATA_W * h) begin
                    p      = (jj - h) / h;
                    e_sclk = (p % 2 == 0);
                    bi     = (p + 1) / 2;
                    if (bi < DATA_W) begin
                        e_mchk = 1'b1;
                        e_mosi = data[DATA_W-1-bi];
                    end
                end else begin
                    e_rsp = 1'b1;
                end
            end
            if (e_rsp) begin
                if (mode == 0) e_rx = data;
                else if (mode == 1) e_rx = '1;
                else for (int b = 0; b < DATA_W; b++) e_rx[DATA_W-1-b] = miso_hist[gap + h + 2 * b * h];
            end

            check_cycle(tag, k, 1'b1, 1'b0, e_sclk, e_rsp,
                        e_sel ? cs_vec(idx, NCS_A) : '0, e_sel ? cs_vec(idx, NCS_B) : '0,
                        e_mchk, e_mosi, e_rsp, e_rx);

            if (rsp_valid_a && obs_rsp_k < 0) begin
                obs_rsp_k = k;
                obs_rsp   = rsp_data_a;
                obs_cs_a  = cs_a;
                obs_cs_b  = cs_b;
            end
            if (s_clk_a && !prev_sclk) begin
                obs_rises++;
                obs_mosi = {obs_mosi[DATA_W-2:0], mosi_a};
            end
            prev_sclk = s_clk_a;

            if (mode == 2) begin
                miso_drv     = 1'($urandom_range(0, 1));
                miso_hist[k] = miso_drv;
            end
            if (k == t) cmd_valid = 1'b0;
            if (k == abort_k) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            @(negedge clk);
            check_reset_vals({tag, " abort"});
            reset     = 1'b0;
            cmd_valid = 1'b0;
            #1;
            check({tag, " post-reset ready_a"}, cmd_ready_a, 1);
            check({tag, " post-reset ready_b"}, cmd_ready_b, 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_cycle({tag, " post-reset"}, k, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
            end
            m_held = 1'b0;
        end else begin
            @(negedge clk);
            check_cycle({tag, " idle"}, t + 1, 1'b0, 1'b1, 1'b0, 1'b0,
                        last ? '0 : cs_vec(idx, NCS_A), last ? '0 : cs_vec(idx, NCS_B),
                        1'b0, 1'b0, 1'b0, '0);
            m_held     = !last;
            m_held_idx = idx;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        do_xfer("basic", 2'd0, 8'hA5, 1'b1, 8'd0, 0, 1'b0, 1'b0);
        check("basic rsp_cycle", obs_rsp_k, 18);
        check("basic rsp_data", obs_rsp, 8'hA5);
        check("basic s_clk_rises", obs_rises, 8);
        check("basic mosi_bits", obs_mosi, 8'hA5);
        check("basic cs_a", obs_cs_a, 4'b0001);

        do_xfer("div", 2'd2, 8'h3C, 1'b1, 8'd3, 1, 1'b0, 1'b0);
        check("div rsp_cycle", obs_rsp_k, 69);
        check("div rsp_data", obs_rsp, 8'hFF);
        check("div mosi_bits", obs_mosi, 8'h3C);
        check("div cs_a", obs_cs_a, 4'b0100);
        check("div cs_b", obs_cs_b, 3'b100);

        do_xfer("hold1", 2'd1, 8'h12, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        check("hold1 cs_a", obs_cs_a, 4'b0010);
        do_xfer("hold2", 2'd1, 8'h5A, 1'b1, 8'd0, 0, 1'b0, 1'b0);
        check("hold2 rsp_cycle", obs_rsp_k, 18);
        check("hold2 rsp_data", obs_rsp, 8'h5A);

        do_xfer("sw1", 2'd1, 8'h81, 1'b0, 8'd0, 2, 1'b0, 1'b0);
        do_xfer("sw2", 2'd3, 8'hC3, 1'b1, 8'd1, 0, 1'b0, 1'b0);
        check("sw2 rsp_cycle", obs_rsp_k, 37);
        check("sw2 rsp_data", obs_rsp, 8'hC3);
        check("sw2 cs_a", obs_cs_a, 4'b1000);
        check("sw2 cs_b out of range", obs_cs_b, 3'b000);

        do_xfer("rst", 2'd2, 8'h96, 1'b1, 8'd1, 2, 1'b0, 1'b1);

        do_xfer("hs1", 2'd0, 8'h69, 1'b1, 8'd1, 2, 1'b1, 1'b0);
        do_xfer("hs2", 2'd3, 8'hE7, 1'b0, 8'd0, 0, 1'b1, 1'b0);
        do_xfer("hs3", 2'd3, 8'h18, 1'b1, 8'd2, 2, 1'b1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            do_xfer($sformatf("rnd%0d", n), CS_W'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), DIV_W'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
